alu_writeback_stage: RTL

Execute-stage back end for the LEGv8 datapath: consumes the combinational ALU outputs (result, negative, zero, overflow, carry_out) plus decoded instruction side-band, holds the architectural NZCV flag register, resolves B.cond/CBZ/CBNZ branch decisions, and buffers results in a 2-entry valid/ready queue feeding the memory/writeback stage.

---
 rtl/alu_writeback_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// Execute-stage back end: keeps the NZCV flag register, decides branches at
// accept time and buffers results in a 2-entry valid/ready queue that feeds
// the memory/writeback stage.
module alu_writeback_stage #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_negative,
    input  logic                  in_zero,
    input  logic                  in_overflow,
    input  logic                  in_carry_out,
    input  logic                  in_set_flags,
    input  logic                  in_is_bcond,
    input  logic [3:0]            in_cond,
    input  logic                  in_is_cbz,
    input  logic                  in_is_cbnz,
    input  logic [4:0]            in_rd,
    input  logic                  in_reg_write,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [4:0]            out_rd,
    output logic                  out_reg_write,
    output logic                  out_branch_taken,
    output logic [3:0]            nzcv
);

    localparam logic [4:0] XZR = 5'd31;

    // Control state
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic [3:0] nzcv_q, nzcv_d;

    // Payload storage, one slot per queue entry
    logic [DATA_WIDTH-1:0] result_q [2];
    logic [4:0]            rd_q     [2];
    logic                  rw_q     [2];
    logic                  taken_q  [2];

    logic accept;
    logic pop;
    logic taken_d;

    // Evaluate a B.cond condition code against flags packed as {N,Z,C,V}.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: cond_holds = z;
            4'b0001: cond_holds = ~z;
            4'b0010: cond_holds = c;
            4'b0011: cond_holds = ~c;
            4'b0100: cond_holds = n;
            4'b0101: cond_holds = ~n;
            4'b0110: cond_holds = v;
            4'b0111: cond_holds = ~v;
            4'b1000: cond_holds = c & ~z;
            4'b1001: cond_holds = ~(c & ~z);
            4'b1010: cond_holds = (n == v);
            4'b1011: cond_holds = (n != v);
            4'b1100: cond_holds = ~z & (n == v);
            4'b1101: cond_holds = ~(~z & (n == v));
            default: cond_holds = 1'b1;
        endcase
    endfunction

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_result       = result_q[rd_ptr_q];
    assign out_rd           = rd_q[rd_ptr_q];
    assign out_reg_write    = rw_q[rd_ptr_q];
    assign out_branch_taken = taken_q[rd_ptr_q];
    assign nzcv             = nzcv_q;

    // Branch decision for the incoming instruction; B.cond sees pre-commit flags.
    always_comb begin
        taken_d = 1'b0;
        if (in_is_cbz) begin
            taken_d = in_zero;
        end else if (in_is_cbnz) begin
            taken_d = ~in_zero;
        end else if (in_is_bcond) begin
            taken_d = cond_holds(in_cond, nzcv_q);
        end
    end

    // Next-state for queue occupancy, pointers and flags; flush wins over everything.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        nzcv_d   = nzcv_q;
        if (flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = ~wr_ptr_q;
                if (in_set_flags) begin
                    nzcv_d = {in_negative, in_zero, in_carry_out, in_overflow};
                end
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({accept, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            nzcv_q   <= 4'b0000;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            nzcv_q   <= nzcv_d;
        end
    end

    // Payload slots: cleared on reset, written at the write pointer on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                result_q[i] <= '0;
                rd_q[i]     <= '0;
                rw_q[i]     <= 1'b0;
                taken_q[i]  <= 1'b0;
            end
        end else if (accept && !flush) begin
            result_q[wr_ptr_q] <= in_result;
            rd_q[wr_ptr_q]     <= in_rd;
            rw_q[wr_ptr_q]     <= in_reg_write & (in_rd != XZR);
            taken_q[wr_ptr_q]  <= taken_d;
        end
    end

endmodule
